pad_tltr_engine: RTL and testbench

- Parametrised, multi-port TH/TR/TL nibble-handshake engine for Saturn peripheral ports, sitting between the SMPC port registers (PDRxO/DDRx) and the per-device data formatters (mouse, wheel, mission stick, 3D pad, multitap).
- Each port serialises a variable-length nibble payload under the SMPC's TR toggling.
- Adds three features:
  - a payload snapshot at transfer start, for coherent multi-nibble reads;
  - a stall timeout;
  - per-port done/timeout strobes.
- All state advances only on SMPC_CE.

---
 rtl/pad_tltr_engine.sv | 181 ++++++++++++++++++
 tb/tb_pad_tltr_engine.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_tltr_engine.sv
// pad_tltr_engine: multi-port TH/TR/TL nibble handshake engine.
// Each port serialises a snapshotted nibble payload under SMPC TR toggling.
module pad_tltr_engine #(
    parameter int         NUM_PORTS  = 2,
    parameter int         MAX_NIB    = 16,
    parameter int         TIMEOUT_CE = 4096,
    parameter logic [3:0] IDLE_NIB   = 4'h0
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic                           SMPC_CE,
    input  logic [7*NUM_PORTS-1:0]         PDRO,
    input  logic [NUM_PORTS-1:0]           EN,
    input  logic [5*NUM_PORTS-1:0]         LEN,
    input  logic [4*MAX_NIB*NUM_PORTS-1:0] PAYLOAD,
    output logic [4*NUM_PORTS-1:0]         DATA_OUT,
    output logic [NUM_PORTS-1:0]           TL_OUT,
    output logic [NUM_PORTS-1:0]           ACTIVE,
    output logic [NUM_PORTS-1:0]           DONE,
    output logic [NUM_PORTS-1:0]           TIMEOUT
);
    localparam int IW = $clog2(MAX_NIB + 1);
    localparam int TW = $clog2(TIMEOUT_CE) + 1;
    localparam int SW = 4 * MAX_NIB;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CE - 1);
    localparam logic [IW-1:0] L_MAX  = IW'(MAX_NIB);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_HOLD
    } state_t;

    // PDRO[4:0] of every port plays no part in the handshake.
    logic [NUM_PORTS-1:0] unused_pdro;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [1:0]    ph;
        logic [4:0]    len_raw;
        logic [IW-1:0] len_eff;
        logic [SW-1:0] pay;
        logic [IW+1:0] sel;
        logic          match;

        state_t        st_q, st_d;
        logic [IW-1:0] idx_q, idx_d;
        logic [IW-1:0] len_q, len_d;
        logic [TW-1:0] tmr_q, tmr_d;
        logic [SW-1:0] snap_q, snap_d;
        logic [3:0]    dat_q, dat_d;
        logic          tl_q, tl_d;
        logic          act_q, act_d;
        logic          done_q, done_d;
        logic          to_q, to_d;
        logic          arm_q, arm_d;

        assign unused_pdro[p] = ^PDRO[7*p +: 5];

        assign ph      = PDRO[7*p+5 +: 2];
        assign len_raw = LEN[5*p +: 5];
        assign pay     = PAYLOAD[SW*p +: SW];
        assign sel     = {idx_q, 2'b00};
        assign len_eff = (32'(len_raw) > MAX_NIB) ? L_MAX : IW'(len_raw);

        // Even nibbles are requested with TR=1, odd nibbles with TR=0.
        assign match = (ph == {1'b0, ~idx_q[0]});

        // Per-port state and registered outputs.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                st_q   <= S_IDLE;
                idx_q  <= '0;
                len_q  <= '0;
                tmr_q  <= '0;
                snap_q <= '0;
                dat_q  <= IDLE_NIB;
                tl_q   <= 1'b1;
                act_q  <= 1'b0;
                done_q <= 1'b0;
                to_q   <= 1'b0;
                arm_q  <= 1'b1;
            end else begin
                st_q   <= st_d;
                idx_q  <= idx_d;
                len_q  <= len_d;
                tmr_q  <= tmr_d;
                snap_q <= snap_d;
                dat_q  <= dat_d;
                tl_q   <= tl_d;
                act_q  <= act_d;
                done_q <= done_d;
                to_q   <= to_d;
                arm_q  <= arm_d;
            end
        end

        // Next state: TH-high/disable abort, then handshake, then stall timeout.
        always_comb begin
            st_d   = st_q;
            idx_d  = idx_q;
            len_d  = len_q;
            tmr_d  = tmr_q;
            snap_d = snap_q;
            dat_d  = dat_q;
            tl_d   = tl_q;
            act_d  = act_q;
            done_d = done_q;
            to_d   = to_q;
            arm_d  = arm_q;
            if (SMPC_CE) begin
                done_d = 1'b0;
                to_d   = 1'b0;
                if (ph == 2'b11 || !EN[p]) begin
                    st_d  = S_IDLE;
                    idx_d = '0;
                    tmr_d = '0;
                    dat_d = IDLE_NIB;
                    tl_d  = 1'b1;
                    act_d = 1'b0;
                    if (ph == 2'b11) begin
                        arm_d = 1'b1;
                    end
                end else begin
                    case (st_q)
                        S_IDLE: begin
                            if (arm_q && ph == 2'b01 && len_eff != '0) begin
                                snap_d = pay;
                                len_d  = len_eff;
                                dat_d  = pay[3:0];
                                tl_d   = 1'b1;
                                idx_d  = IW'(1);
                                tmr_d  = '0;
                                if (len_eff == IW'(1)) begin
                                    st_d   = S_HOLD;
                                    done_d = 1'b1;
                                    act_d  = 1'b0;
                                end else begin
                                    st_d  = S_XFER;
                                    act_d = 1'b1;
                                end
                            end
                        end
                        S_XFER: begin
                            if (match) begin
                                dat_d = snap_q[sel +: 4];
                                tl_d  = ~idx_q[0];
                                idx_d = idx_q + IW'(1);
                                tmr_d = '0;
                                if (idx_q == len_q - IW'(1)) begin
                                    st_d   = S_HOLD;
                                    done_d = 1'b1;
                                    act_d  = 1'b0;
                                end
                            end else if (tmr_q == T_LAST) begin
                                st_d  = S_IDLE;
                                idx_d = '0;
                                tmr_d = '0;
                                dat_d = IDLE_NIB;
                                tl_d  = 1'b1;
                                act_d = 1'b0;
                                to_d  = 1'b1;
                                arm_d = 1'b0;
                            end else if (tmr_q != '1) begin
                                tmr_d = tmr_q + TW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        assign DATA_OUT[4*p +: 4] = dat_q;
        assign TL_OUT[p]          = tl_q;
        assign ACTIVE[p]          = act_q;
        assign DONE[p]            = done_q;
        assign TIMEOUT[p]         = to_q;
    end

endmodule

// File: tb/tb_pad_tltr_engine.sv
// tb_pad_tltr_engine: directed + randomized checks of pad_tltr_engine
// against a transaction-level model of each port's nibble stream.
module tb_pad_tltr_engine;
    localparam int         NP = 2;
    localparam int         MN = 16;
    localparam int         TO = 8;
    localparam logic [3:0] IN = 4'h6;

    logic                   CLK = 1'b0;
    logic                   RST_N = 1'b0;
    logic                   SMPC_CE = 1'b0;
    logic [7*NP-1:0]        PDRO = '0;
    logic [NP-1:0]          EN = '0;
    logic [5*NP-1:0]        LEN = '0;
    logic [4*MN*NP-1:0]     PAYLOAD = '0;
    logic [4*NP-1:0]        DATA_OUT;
    logic [NP-1:0]          TL_OUT;
    logic [NP-1:0]          ACTIVE;
    logic [NP-1:0]          DONE;
    logic [NP-1:0]          TIMEOUT;

    int checks = 0;
    int failures = 0;

    logic [1:0] ph [NP];

    // Model: 0 idle, 1 transferring, 2 finished
    int         m_state [NP];
    int         m_sent  [NP];
    int         m_len   [NP];
    int         m_quiet [NP];
    bit         m_arm   [NP];
    logic [3:0] m_snap  [NP][MN];
    logic [3:0] m_data  [NP];
    logic       m_tl    [NP];
    logic       m_act   [NP];
    logic       m_done  [NP];
    logic       m_to    [NP];

    logic [3:0] orig [MN];

    pad_tltr_engine #(
        .NUM_PORTS (NP),
        .MAX_NIB   (MN),
        .TIMEOUT_CE(TO),
        .IDLE_NIB  (IN)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SMPC_CE (SMPC_CE),
        .PDRO    (PDRO),
        .EN      (EN),
        .LEN     (LEN),
        .PAYLOAD (PAYLOAD),
        .DATA_OUT(DATA_OUT),
        .TL_OUT  (TL_OUT),
        .ACTIVE  (ACTIVE),
        .DONE    (DONE),
        .TIMEOUT (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int p,
                       input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s p%0d obs=%h exp=%h", tag, p, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NP; p++) begin
            chk({tag, "/data"}, p, DATA_OUT[4*p +: 4], m_data[p]);
            chk({tag, "/tl"}, p, {3'b0, TL_OUT[p]}, {3'b0, m_tl[p]});
            chk({tag, "/act"}, p, {3'b0, ACTIVE[p]}, {3'b0, m_act[p]});
            chk({tag, "/done"}, p, {3'b0, DONE[p]}, {3'b0, m_done[p]});
            chk({tag, "/tmo"}, p, {3'b0, TIMEOUT[p]}, {3'b0, m_to[p]});
        end
    endtask

    function automatic logic [3:0] pay_nib(input int p, input int k);
        return PAYLOAD[(p*MN + k)*4 +: 4];
    endfunction

    task automatic set_nib(input int p, input int k, input logic [3:0] v);
        PAYLOAD[(p*MN + k)*4 +: 4] = v;
    endtask

    task automatic m_go_idle(input int p);
        m_state[p] = 0;
        m_sent[p]  = 0;
        m_quiet[p] = 0;
        m_data[p]  = IN;
        m_tl[p]    = 1'b1;
        m_act[p]   = 1'b0;
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_go_idle(p);
            m_arm[p]  = 1'b1;
            m_len[p]  = 0;
            m_done[p] = 1'b0;
            m_to[p]   = 1'b0;
            for (int k = 0; k < MN; k++) m_snap[p][k] = 4'h0;
        end
    endtask

    // One CE tick of the nibble-stream model, using the inputs now applied.
    task automatic model_step();
        int L;
        int want;
        for (int p = 0; p < NP; p++) begin
            m_done[p] = 1'b0;
            m_to[p]   = 1'b0;
            L = int'(LEN[5*p +: 5]);
            if (L > MN) L = MN;
            if (ph[p] == 2'b11 || !EN[p]) begin
                m_go_idle(p);
                if (ph[p] == 2'b11) m_arm[p] = 1'b1;
            end else if (m_state[p] == 0) begin
                if (m_arm[p] && ph[p] == 2'b01 && L > 0) begin
                    for (int k = 0; k < MN; k++) m_snap[p][k] = pay_nib(p, k);
                    m_len[p]   = L;
                    m_sent[p]  = 1;
                    m_quiet[p] = 0;
                    m_data[p]  = m_snap[p][0];
                    m_tl[p]    = 1'b1;
                    if (L == 1) begin
                        m_state[p] = 2;
                        m_done[p]  = 1'b1;
                        m_act[p]   = 1'b0;
                    end else begin
                        m_state[p] = 1;
                        m_act[p]   = 1'b1;
                    end
                end
            end else if (m_state[p] == 1) begin
                want = (m_sent[p] % 2 == 0) ? 1 : 0;
                if (int'(ph[p]) == want) begin
                    m_data[p]  = m_snap[p][m_sent[p]];
                    m_tl[p]    = (m_sent[p] % 2 == 0);
                    m_sent[p]  = m_sent[p] + 1;
                    m_quiet[p] = 0;
                    if (m_sent[p] == m_len[p]) begin
                        m_state[p] = 2;
                        m_done[p]  = 1'b1;
                        m_act[p]   = 1'b0;
                    end
                end else begin
                    m_quiet[p] = m_quiet[p] + 1;
                    if (m_quiet[p] == TO) begin
                        m_go_idle(p);
                        m_to[p]  = 1'b1;
                        m_arm[p] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic drive_pdro();
        for (int p = 0; p < NP; p++) begin
            PDRO[7*p +: 7] = {ph[p], 5'($urandom)};
        end
    endtask

    // One CE tick, sometimes preceded by a clock with CE low.
    task automatic tick();
        drive_pdro();
        if ($urandom_range(0, 3) == 0) begin
            SMPC_CE = 1'b0;
            @(posedge CLK);
            #1;
            check_all("noce");
            drive_pdro();
        end
        SMPC_CE = 1'b1;
        model_step();
        @(posedge CLK);
        #1;
        SMPC_CE = 1'b0;
        check_all("ce");
    endtask

    task automatic toggle(input int p);
        ph[p] = (ph[p] == 2'b01) ? 2'b00 : 2'b01;
    endtask

    task automatic run_toggles(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            toggle(p);
            tick();
        end
    endtask

    task automatic rand_payload(input int p);
        for (int k = 0; k < MN; k++) set_nib(p, k, 4'($urandom));
    endtask

    initial begin
        int r;
        ph[0] = 2'b11;
        ph[1] = 2'b11;
        model_reset();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset");
        RST_N = 1'b1;

        // Mouse-style transfer on port0, port1 disabled but toggling
        EN = 2'b01;
        LEN[4:0] = 5'd10;
        LEN[9:5] = 5'd16;
        set_nib(0, 0, 4'hB); set_nib(0, 1, 4'hF);
        set_nib(0, 2, 4'hF); set_nib(0, 3, 4'h0);
        set_nib(0, 4, 4'h8); set_nib(0, 5, 4'h1);
        set_nib(0, 6, 4'h2); set_nib(0, 7, 4'h3);
        set_nib(0, 8, 4'h4); set_nib(0, 9, 4'hC);
        rand_payload(1);
        tick();
        for (int i = 0; i < 10; i++) begin
            toggle(0);
            toggle(1);
            tick();
            chk("en0_data", 1, DATA_OUT[7:4], IN);
        end
        chk("mouse_done", 0, {3'b0, DONE[0]}, 4'h1);
        chk("mouse_last", 0, DATA_OUT[3:0], 4'hC);
        chk("mouse_tl", 0, {3'b0, TL_OUT[0]}, 4'h0);
        toggle(0);
        tick();
        chk("mouse_extra", 0, DATA_OUT[3:0], 4'hC);
        chk("mouse_act", 0, {3'b0, ACTIVE[0]}, 4'h0);

        // Snapshot coherency
        LEN[4:0] = 5'd16;
        rand_payload(0);
        for (int k = 0; k < MN; k++) orig[k] = pay_nib(0, k);
        ph[0] = 2'b11;
        tick();
        for (int k = 0; k < MN; k++) begin
            if (k == 4) for (int j = 0; j < MN; j++) set_nib(0, j, 4'hA);
            toggle(0);
            tick();
            chk("snap", 0, DATA_OUT[3:0], orig[k]);
        end

        // TH abort mid-transfer, then restart at nibble0
        rand_payload(0);
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 6);
        ph[0] = 2'b11;
        tick();
        chk("th_data", 0, DATA_OUT[3:0], IN);
        chk("th_done", 0, {3'b0, DONE[0]}, 4'h0);
        toggle(0);
        tick();
        chk("th_restart", 0, DATA_OUT[3:0], pay_nib(0, 0));

        // Stall timeout after nibble 2
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 3);
        repeat (TO - 1) tick();
        chk("tmo_early", 0, {3'b0, TIMEOUT[0]}, 4'h0);
        tick();
        chk("tmo_pulse", 0, {3'b0, TIMEOUT[0]}, 4'h1);
        chk("tmo_data", 0, DATA_OUT[3:0], IN);
        toggle(0);
        tick();
        toggle(0);
        tick();
        chk("tmo_noarm", 0, {3'b0, ACTIVE[0]}, 4'h0);

        // Toggle landing on the final tick advances instead
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 3);
        repeat (TO - 1) tick();
        toggle(0);
        tick();
        chk("tmo_win", 0, {3'b0, TIMEOUT[0]}, 4'h0);
        chk("tmo_adv", 0, DATA_OUT[3:0], pay_nib(0, 3));

        // Two ports interleaved
        EN = 2'b11;
        LEN[4:0] = 5'd10;
        LEN[9:5] = 5'd16;
        rand_payload(0);
        rand_payload(1);
        ph[0] = 2'b11;
        ph[1] = 2'b11;
        tick();
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 2);
            if (r != 1) toggle(0);
            if (r != 0) toggle(1);
            tick();
        end
        chk("ind_hold0", 0, DATA_OUT[3:0], pay_nib(0, 9));
        chk("ind_hold1", 1, DATA_OUT[7:4], pay_nib(1, 15));

        // LEN=0 never starts
        LEN[4:0] = 5'd0;
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 2);
        chk("len0", 0, {3'b0, ACTIVE[0]}, 4'h0);

        // LEN beyond MAX_NIB clips
        LEN[4:0] = 5'd20;
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 15);
        chk("len20_pre", 0, {3'b0, DONE[0]}, 4'h0);
        run_toggles(0, 1);
        chk("len20_done", 0, {3'b0, DONE[0]}, 4'h1);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            for (int p = 0; p < NP; p++) begin
                r = $urandom_range(0, 99);
                if (r < 70) toggle(p);
                else if (r < 75) ph[p] = 2'b11;
            end
            if ($urandom_range(0, 49) == 0)
                EN = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b11;
            if ($urandom_range(0, 9) == 0)
                LEN = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0) begin
                rand_payload(0);
                rand_payload(1);
            end
            if ($urandom_range(0, 59) == 0) repeat (TO + 1) tick();
            tick();
        end

        // Asynchronous reset mid-transfer
        EN = 2'b11;
        LEN[4:0] = 5'd12;
        ph[0] = 2'b11;
        tick();
        run_toggles(0, 3);
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check_all("async");
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        check_all("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
